// File: rtl/fir_frame_sched_if.sv
// Pixel handshake bundle between the frame scheduler, its pixel source and the 2D FIR datapath.
// The slave modport is the scheduler's view; master is the source/datapath side.
interface fir_frame_sched_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    logic                  dn_ready;
    logic                  fir_valid;
    logic [DATA_WIDTH-1:0] fir_data;

    modport master (
        output src_valid, src_data, dn_ready,
        input  src_ready, fir_valid, fir_data
    );

    modport slave (
        input  src_valid, src_data, dn_ready,
        output src_ready, fir_valid, fir_data
    );
endinterface

// File: rtl/fir_frame_sched.sv
// Frame scheduler for a 2D FIR: emits top pad lines, the source frame, bottom pad lines,
// then drains the datapath, with shadowed size/coefficient configuration.
module fir_frame_sched #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LINE_CNT    = 12,
    parameter int unsigned COEFF_WIDTH = 14,
    parameter int unsigned PAD_LINES   = 1,
    parameter int unsigned PAD_VALUE   = 0,
    parameter int unsigned FLUSH_CYC   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [LINE_CNT-1:0]      cfg_h_size_i,
    input  logic [LINE_CNT-1:0]      cfg_v_size_i,
    input  logic [6*COEFF_WIDTH-1:0] cfg_coeff_i,
    fir_frame_sched_if.slave         pix_if,
    output logic                     fir_ce_o,
    output logic [LINE_CNT-1:0]      fir_h_size_o,
    output logic [LINE_CNT-1:0]      fir_v_size_o,
    output logic [6*COEFF_WIDTH-1:0] fir_coeff_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);
    localparam int unsigned FlushW = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;
    localparam logic [LINE_CNT-1:0]   PadLast   = LINE_CNT'(PAD_LINES - 1);
    localparam logic [LINE_CNT-1:0]   PadSpan   = LINE_CNT'(2 * PAD_LINES);
    localparam logic [LINE_CNT:0]     PadSpanW  = (LINE_CNT + 1)'(2 * PAD_LINES);
    localparam logic [FlushW-1:0]     FlushLast = FlushW'(FLUSH_CYC - 1);
    localparam logic [DATA_WIDTH-1:0] PadPix    = DATA_WIDTH'(PAD_VALUE);

    typedef enum logic [2:0] {
        StIdle, StPadTop, StActive, StPadBot, StFlush, StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [LINE_CNT-1:0]      h_q, h_d;
    logic [LINE_CNT-1:0]      v_q, v_d;
    logic [6*COEFF_WIDTH-1:0] coeff_q, coeff_d;
    logic [LINE_CNT-1:0]      x_q, x_d;
    logic [LINE_CNT-1:0]      y_q, y_d;
    logic [FlushW-1:0]        flush_q, flush_d;
    logic                     fir_valid_q, fir_valid_d;
    logic [DATA_WIDTH-1:0]    fir_data_q, fir_data_d;
    logic                     err_q, err_d;

    logic                advance;
    logic                beat;
    logic                done;
    logic                src_ready;
    logic                cfg_legal;
    logic                flush_done;
    logic [LINE_CNT:0]   v_pad_wide;
    logic [LINE_CNT-1:0] last_y;

    // v shadow holds the padded last-line index so the output reads 0 straight out of reset
    assign v_pad_wide = {1'b0, cfg_v_size_i} + PadSpanW;
    assign cfg_legal  = (cfg_h_size_i >= LINE_CNT'(2)) && (cfg_v_size_i >= LINE_CNT'(1)) &&
                        !v_pad_wide[LINE_CNT];
    assign advance    = !fir_valid_q || pix_if.dn_ready;
    assign last_y     = (state_q == StActive) ? (v_q - PadSpan) : PadLast;
    assign flush_done = (FLUSH_CYC == 0) || (!fir_valid_q && (flush_q == FlushLast));

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        coeff_d     = coeff_q;
        x_d         = x_q;
        y_d         = y_q;
        flush_d     = flush_q;
        fir_valid_d = fir_valid_q;
        fir_data_d  = fir_data_q;
        err_d       = 1'b0;
        beat        = 1'b0;
        done        = 1'b0;
        src_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (advance) fir_valid_d = 1'b0;
                if (start_i && !abort_i) begin
                    if (cfg_legal) begin
                        h_d     = cfg_h_size_i;
                        v_d     = v_pad_wide[LINE_CNT-1:0];
                        coeff_d = cfg_coeff_i;
                        x_d     = '0;
                        y_d     = '0;
                        flush_d = '0;
                        state_d = (PAD_LINES == 0) ? StActive : StPadTop;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPadTop, StPadBot: begin
                if (advance) begin
                    fir_valid_d = 1'b1;
                    fir_data_d  = PadPix;
                    beat        = 1'b1;
                end
            end
            StActive: begin
                src_ready = advance && !abort_i;
                if (advance) begin
                    fir_valid_d = pix_if.src_valid;
                    if (pix_if.src_valid) begin
                        fir_data_d = pix_if.src_data;
                        beat       = 1'b1;
                    end
                end
            end
            StFlush: begin
                if (advance) fir_valid_d = 1'b0;
                if (!fir_valid_q) flush_d = flush_q + FlushW'(1);
                if (flush_done) state_d = StDone;
            end
            StDone: begin
                if (advance) fir_valid_d = 1'b0;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Region changes on the edge that loads the region's last pixel
        if (beat) begin
            if (x_q == h_q) begin
                x_d = '0;
                if (y_q == last_y) begin
                    y_d = '0;
                    if (state_q == StPadTop) begin
                        state_d = StActive;
                    end else if (state_q == StActive) begin
                        state_d = (PAD_LINES == 0) ? StFlush : StPadBot;
                    end else begin
                        state_d = StFlush;
                    end
                end else begin
                    y_d = y_q + LINE_CNT'(1);
                end
            end else begin
                x_d = x_q + LINE_CNT'(1);
            end
        end

        if (abort_i) begin
            state_d     = StIdle;
            fir_valid_d = 1'b0;
            done        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            h_q         <= '0;
            v_q         <= '0;
            coeff_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            flush_q     <= '0;
            fir_valid_q <= 1'b0;
            fir_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            coeff_q     <= coeff_d;
            x_q         <= x_d;
            y_q         <= y_d;
            flush_q     <= flush_d;
            fir_valid_q <= fir_valid_d;
            fir_data_q  <= fir_data_d;
            err_q       <= err_d;
        end
    end

    assign pix_if.src_ready = src_ready;
    assign pix_if.fir_valid = fir_valid_q;
    assign pix_if.fir_data  = fir_data_q;
    assign fir_h_size_o     = h_q;
    assign fir_v_size_o     = v_q;
    assign fir_coeff_o      = coeff_q;
    assign busy_o           = (state_q != StIdle);
    assign fir_ce_o         = (state_q != StIdle);
    assign done_o           = done;
    assign err_o            = err_q;
endmodule

// File: tb/tb_fir_frame_sched.sv
// Directed bench for fir_frame_sched: a queue model of the padded output stream is checked
// every cycle, plus literal timing, error, abort, ignored-start and async-reset checks.
module tb_fir_frame_sched;
    localparam int unsigned DW = 8;
    localparam int unsigned LC = 12;
    localparam int unsigned CW = 14;
    localparam logic [6*CW-1:0] CoeffA = 84'h123456789ABCDEF012345;
    localparam logic [6*CW-1:0] CoeffB = 84'hFEDCBA9876543210FEDCB;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic [LC-1:0]  cfg_h;
    logic [LC-1:0]  cfg_v;
    logic [6*CW-1:0] cfg_coeff;
    logic           fir_ce;
    logic [LC-1:0]  h_o;
    logic [LC-1:0]  v_o;
    logic [6*CW-1:0] coeff_o;
    logic           busy;
    logic           done;
    logic           err;

    fir_frame_sched_if #(.DATA_WIDTH(DW)) s_if ();

    fir_frame_sched #(
        .DATA_WIDTH(DW), .LINE_CNT(LC), .COEFF_WIDTH(CW),
        .PAD_LINES(1), .PAD_VALUE(0), .FLUSH_CYC(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .cfg_h_size_i(cfg_h),
        .cfg_v_size_i(cfg_v),
        .cfg_coeff_i (cfg_coeff),
        .pix_if      (s_if),
        .fir_ce_o    (fir_ce),
        .fir_h_size_o(h_o),
        .fir_v_size_o(v_o),
        .fir_coeff_o (coeff_o),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc_cnt = 0;
    int drv_cnt = 0;
    logic [DW-1:0] exp_q[$];
    int src_idx = 0;
    int src_total = 0;
    int base = 0;
    bit dn_toggle = 0;
    bit sv_gap = 0;
    bit chk_en = 0;
    bit acc_seen = 0;
    bit stall_prev = 0;
    bit acc_prev = 0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] acc_data = '0;
    int beats = 0;
    int first_valid_cyc = 0;
    int last_valid_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;

    function automatic logic [DW-1:0] pix(input int b, input int i);
        return {1'b1, 7'(b + i * 13)};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_tot++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Per-cycle model comparison, sampled at the falling edge
    task automatic compare_cycle();
        cyc_cnt++;
        if (chk_en) begin
            if (stall_prev) begin
                chk("hold_valid", s_if.fir_valid, 1);
                chk("hold_data", s_if.fir_data, prev_data);
            end
            if (acc_prev) begin
                chk("src_latency_valid", s_if.fir_valid, 1);
                chk("src_latency_data", s_if.fir_data, acc_data);
            end
            if (s_if.fir_valid && s_if.dn_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("stream_extra_beat");
                end else begin
                    chk("stream", s_if.fir_data, exp_q.pop_front());
                end
                if (beats == 0) first_valid_cyc = cyc_cnt;
                beats++;
                last_valid_cyc = cyc_cnt;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_cnt;
        end
        stall_prev = s_if.fir_valid && !s_if.dn_ready;
        prev_data  = s_if.fir_data;
        acc_prev   = s_if.src_valid && s_if.src_ready;
        acc_data   = s_if.src_data;
        acc_seen   = acc_prev;
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
        if (acc_seen) src_idx++;
        drv_cnt++;
        s_if.dn_ready  = dn_toggle ? (drv_cnt % 2 == 0) : 1'b1;
        s_if.src_valid = (src_idx < src_total) && (!sv_gap || (drv_cnt % 3 != 0));
        s_if.src_data  = pix(base, src_idx);
    endtask

    task automatic start_frame(input int h, input int v, input int b,
                               input logic [6*CW-1:0] c);
        cfg_h = LC'(h);
        cfg_v = LC'(v);
        cfg_coeff = c;
        base = b;
        src_idx = 0;
        src_total = (h + 1) * (v + 1);
        exp_q.delete();
        for (int i = 0; i < h + 1; i++) exp_q.push_back('0);
        for (int i = 0; i < src_total; i++) exp_q.push_back(pix(b, i));
        for (int i = 0; i < h + 1; i++) exp_q.push_back('0);
        beats = 0;
        s_if.src_valid = 1'b1;
        s_if.src_data = pix(b, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc_cnt;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) begin
                seen = 1;
                break;
            end
            step();
        end
        if (!seen) fail_now(name);
    endtask

    task automatic wait_src(input int target, input int budget, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (src_idx >= target) begin
                seen = 1;
                break;
            end
            step();
        end
        if (!seen) fail_now(name);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fir_valid"}, s_if.fir_valid, 0);
        chk({tag, "_fir_data"}, s_if.fir_data, 0);
        chk({tag, "_src_ready"}, s_if.src_ready, 0);
        chk({tag, "_busy_ce"}, {busy, fir_ce}, 0);
        chk({tag, "_done_err"}, {done, err}, 0);
        chk({tag, "_sizes"}, {h_o, v_o}, 0);
        chk({tag, "_coeff"}, coeff_o, 0);
    endtask

    initial begin
        logic [LC-1:0] bad_h[3];
        logic [LC-1:0] bad_v[3];
        int d0;
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_h = '0;
        cfg_v = '0;
        cfg_coeff = '0;
        s_if.src_valid = 1'b0;
        s_if.src_data = '0;
        s_if.dn_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        step();
        chk_en = 1;

        // Frame A: h=3, v=2, source always valid, datapath always ready
        start_frame(3, 2, 16, CoeffA);
        chk("A_v_size_padded", v_o, 4);
        chk("A_h_size", h_o, 3);
        chk("A_coeff", coeff_o, CoeffA);
        chk("A_busy_ce", {busy, fir_ce}, 2'b11);
        wait_done(100, "A_done_timeout");
        chk("A_beats", beats, 20);
        chk("A_first_latency", first_valid_cyc - start_cyc, 2);
        chk("A_contiguous", last_valid_cyc - first_valid_cyc, 19);
        chk("A_flush_gap", done_cyc - last_valid_cyc, 9);
        chk("A_queue_drained", exp_q.size(), 0);
        chk("A_done_one_cycle", done, 0);
        chk("A_idle_busy", busy, 0);

        // Frame B: minimal legal size with a gappy source and a stalling datapath
        dn_toggle = 1;
        sv_gap = 1;
        start_frame(2, 1, 77, CoeffB);
        wait_done(300, "B_done_timeout");
        chk("B_beats", beats, 12);
        chk("B_queue_drained", exp_q.size(), 0);
        dn_toggle = 0;
        sv_gap = 0;
        step();

        // Illegal configurations: h too small, v too small, padded v overflow
        bad_h[0] = 12'd1;  bad_v[0] = 12'd2;
        bad_h[1] = 12'd3;  bad_v[1] = 12'd0;
        bad_h[2] = 12'd3;  bad_v[2] = 12'd4094;
        for (int i = 0; i < 3; i++) begin
            cfg_h = bad_h[i];
            cfg_v = bad_v[i];
            cfg_coeff = CoeffA;
            start = 1'b1;
            step();
            start = 1'b0;
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_shadow", {h_o, v_o}, {12'd2, 12'd3});
            chk("err_coeff", coeff_o, CoeffB);
            step();
            chk("err_one_cycle", err, 0);
        end

        // Abort while the 5th source pixel is offered
        start_frame(3, 2, 40, CoeffA);
        wait_src(4, 60, "abort_reach_timeout");
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        src_total = 0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", s_if.fir_valid, 0);
        chk("abort_shadow", h_o, 3);
        d0 = done_cnt;
        for (int i = 0; i < 12; i++) step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_pixels_out", beats, 8);

        start_frame(3, 2, 90, CoeffB);
        wait_done(100, "post_abort_timeout");
        chk("post_abort_beats", beats, 20);
        chk("post_abort_drained", exp_q.size(), 0);

        // New start request mid-frame is ignored
        start_frame(3, 2, 120, CoeffA);
        wait_src(5, 60, "ignore_reach_timeout");
        cfg_h = 12'd7;
        cfg_v = 12'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ignore_h", h_o, 3);
        chk("ignore_v", v_o, 4);
        chk("ignore_busy", busy, 1);
        wait_done(100, "ignore_done_timeout");
        chk("ignore_beats", beats, 20);
        chk("ignore_drained", exp_q.size(), 0);

        // Asynchronous reset during the bottom pad line
        start_frame(3, 2, 200, CoeffB);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 60; i++) begin
                if (beats >= 17) begin
                    seen = 1;
                    break;
                end
                step();
            end
            if (!seen) fail_now("padbot_reach_timeout");
        end
        chk("padbot_pre_valid", s_if.fir_valid, 1);
        chk("padbot_pre_data", s_if.fir_data, 0);
        chk("padbot_pre_busy", busy, 1);
        chk_en = 0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        src_total = 0;
        step();
        chk("post_reset_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
